// File: rtl/counter_checker_if.sv
`default_nettype none
//==============================================================================
// Module      : counter_checker_if
// Description : Bundle of the Counter stimulus/output as seen by the checker,
//               plus the checker's verdict signals.
// Revision    : 1.0 - initial release
//==============================================================================
interface counter_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) ();
    logic             enb;
    logic [1:0]       modo;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] Q;
    logic             synced;
    logic             err;
    logic             fail;
    logic [ERR_W-1:0] err_cnt;
    logic [15:0]      chk_cnt;
    logic [WIDTH-1:0] first_exp;
    logic [WIDTH-1:0] first_got;

    // Probador side: drives the Counter stimulus and observes the verdict.
    modport master (
        output enb, modo, data, Q,
        input  synced, err, fail, err_cnt, chk_cnt, first_exp, first_got
    );

    // Checker side: purely passive on the Counter signals.
    modport slave (
        input  enb, modo, data, Q,
        output synced, err, fail, err_cnt, chk_cnt, first_exp, first_got
    );
endinterface
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
//==============================================================================
// Module      : counter_checker
// Description : Passive scoreboard for the 4-bit Counter. A reference model
//               predicts Q one cycle ahead and every mismatch is flagged,
//               counted and (the first one) captured.
// Revision    : 1.0 - initial release
//==============================================================================
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int STOP_ON_ERR = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    counter_checker_if.slave  bus
);

    localparam logic [1:0]       c_UNSYNC = 2'd0;
    localparam logic [1:0]       c_CHECK  = 2'd1;
    localparam logic [1:0]       c_FAIL   = 2'd2;
    localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_THREE  = WIDTH'(3);
    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic             r_p_enb;
    logic [1:0]       r_p_modo;
    logic [WIDTH-1:0] r_p_data;
    logic [WIDTH-1:0] r_p_q;
    logic [WIDTH-1:0] r_model;

    logic             r_err;
    logic             r_fail;
    logic [ERR_W-1:0] r_err_cnt;
    logic [15:0]      r_chk_cnt;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_got;

    logic             w_sync_hit;
    logic             w_cmp;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_exp;
    logic             w_mis;

    // Counter transfer function: value after one edge with the given controls.
    function automatic logic [WIDTH-1:0] f_next(
        input logic [WIDTH-1:0] base,
        input logic             en,
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] ld
    );
        if (!en) return base;
        case (mode)
            2'b00:   return base + c_ONE;
            2'b01:   return base - c_ONE;
            2'b10:   return base + c_THREE;
            default: return ld;
        endcase
    endfunction

    // A sampled load locks the model; that same edge checks the load result.
    assign w_sync_hit = r_p_enb && (r_p_modo == 2'b11);
    assign w_cmp      = (r_state == c_CHECK) || ((r_state == c_UNSYNC) && w_sync_hit);
    // Once locked the model follows its own prediction, never the observed Q.
    assign w_base     = (r_state == c_CHECK) ? r_model : r_p_q;
    assign w_exp      = f_next(w_base, r_p_enb, r_p_modo, r_p_data);
    // Case inequality so an X/Z on Q is reported rather than masked.
    assign w_mis      = w_cmp && (bus.Q !== w_exp);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_UNSYNC;
        else       r_state <= w_state_next;
    end

    // Next-state logic: lock on a load, optionally park in FAIL on a mismatch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_UNSYNC: if (w_sync_hit) w_state_next = (w_mis && (STOP_ON_ERR != 0)) ? c_FAIL : c_CHECK;
            c_CHECK:  if (w_mis && (STOP_ON_ERR != 0)) w_state_next = c_FAIL;
            c_FAIL:   w_state_next = c_FAIL;
            default:  w_state_next = c_UNSYNC;
        endcase
    end

    // Sampling pipeline, reference model and mismatch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_enb     <= 1'b0;
            r_p_modo    <= 2'b00;
            r_p_data    <= '0;
            r_p_q       <= '0;
            r_model     <= '0;
            r_err       <= 1'b0;
            r_fail      <= 1'b0;
            r_err_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_p_enb  <= bus.enb;
            r_p_modo <= bus.modo;
            r_p_data <= bus.data;
            r_p_q    <= bus.Q;
            r_err    <= w_mis;
            if (w_cmp) begin
                r_model   <= w_exp;
                r_chk_cnt <= r_chk_cnt + 16'd1;
            end
            if (w_mis) begin
                r_fail <= 1'b1;
                if (r_err_cnt != c_ERR_MAX) r_err_cnt <= r_err_cnt + 1'b1;
                if (!r_fail) begin
                    r_first_exp <= w_exp;
                    r_first_got <= bus.Q;
                end
            end
        end
    end

    assign bus.synced    = (r_state != c_UNSYNC);
    assign bus.err       = r_err;
    assign bus.fail      = r_fail;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.chk_cnt   = r_chk_cnt;
    assign bus.first_exp = r_first_exp;
    assign bus.first_got = r_first_got;

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
//==============================================================================
// Module      : tb_counter_checker
// Description : Directed bench for counter_checker. Three instances share the
//               stimulus: default build, STOP_ON_ERR=1 and ERR_W=2.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_counter_checker;

    logic       clk;
    logic       reset;
    logic       enb;
    logic [1:0] modo;
    logic [3:0] data;
    logic [3:0] q;

    int n_pass;
    int n_total;

    counter_checker_if #(.WIDTH(4), .ERR_W(8)) if0 ();
    counter_checker_if #(.WIDTH(4), .ERR_W(8)) if1 ();
    counter_checker_if #(.WIDTH(4), .ERR_W(2)) if2 ();

    assign if0.enb = enb;  assign if0.modo = modo;  assign if0.data = data;  assign if0.Q = q;
    assign if1.enb = enb;  assign if1.modo = modo;  assign if1.data = data;  assign if1.Q = q;
    assign if2.enb = enb;  assign if2.modo = modo;  assign if2.data = data;  assign if2.Q = q;

    counter_checker #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    counter_checker #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    counter_checker #(.WIDTH(4), .ERR_W(2), .STOP_ON_ERR(0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Present one cycle of Counter stimulus and its Q; return #1 after the edge.
    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] d, input logic [3:0] qv);
        enb  = e;
        modo = m;
        data = d;
        q    = qv;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 2'b00, 4'd0, 4'd0);
        reset = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset = 1'b0; enb = 1'b0; modo = 2'b00; data = 4'd0; q = 4'd0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        chk("rst_synced",  32'(if0.synced),    0);
        chk("rst_err",     32'(if0.err),       0);
        chk("rst_fail",    32'(if0.fail),      0);
        chk("rst_errcnt",  32'(if0.err_cnt),   0);
        chk("rst_chkcnt",  32'(if0.chk_cnt),   0);
        chk("rst_fexp",    32'(if0.first_exp), 0);
        chk("rst_fgot",    32'(if0.first_got), 0);

        // Load 5, count up: Q = 5,6,7,8
        step(1'b1, 2'b11, 4'd5, 4'd0);
        chk("ld5_unsynced", 32'(if0.synced), 0);
        step(1'b1, 2'b00, 4'd0, 4'd5);  chk("up_q5_err", 32'(if0.err), 0);
        chk("ld5_synced", 32'(if0.synced), 1);
        step(1'b1, 2'b00, 4'd0, 4'd6);  chk("up_q6_err", 32'(if0.err), 0);
        step(1'b1, 2'b00, 4'd0, 4'd7);  chk("up_q7_err", 32'(if0.err), 0);
        step(1'b0, 2'b00, 4'd0, 4'd8);  chk("up_q8_err", 32'(if0.err), 0);
        chk("up_chkcnt", 32'(if0.chk_cnt), 4);
        chk("up_fail",   32'(if0.fail),    0);

        // Load 14, +3 twice (14,1,4); load 0, down once (15)
        step(1'b1, 2'b11, 4'd14, 4'd8); chk("hold8_err", 32'(if0.err), 0);
        step(1'b1, 2'b10, 4'd0, 4'd14); chk("ld14_err",  32'(if0.err), 0);
        step(1'b1, 2'b10, 4'd0, 4'd1);  chk("p3_1_err",  32'(if0.err), 0);
        step(1'b1, 2'b11, 4'd0, 4'd4);  chk("p3_4_err",  32'(if0.err), 0);
        step(1'b1, 2'b01, 4'd0, 4'd0);  chk("ld0_err",   32'(if0.err), 0);
        step(1'b0, 2'b00, 4'd0, 4'd15); chk("dn15_err",  32'(if0.err), 0);
        chk("wrap_errcnt", 32'(if0.err_cnt), 0);
        chk("wrap_chkcnt", 32'(if0.chk_cnt), 10);

        // Load 3, hold four cycles, then Q wrongly moves to 4
        step(1'b1, 2'b11, 4'd3, 4'd15);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 4'd0, 4'd3);
            chk("hold3_err", 32'(if0.err), 0);
        end
        step(1'b0, 2'b00, 4'd0, 4'd4);
        chk("bad4_err",    32'(if0.err),       1);
        chk("bad4_errcnt", 32'(if0.err_cnt),   1);
        chk("bad4_fail",   32'(if0.fail),      1);
        chk("bad4_fexp",   32'(if0.first_exp), 3);
        chk("bad4_fgot",   32'(if0.first_got), 4);
        step(1'b0, 2'b00, 4'd0, 4'd3);
        chk("after_err",    32'(if0.err),     0);
        chk("after_fail",   32'(if0.fail),    1);
        chk("after_chkcnt", 32'(if0.chk_cnt), 17);

        // Never loading: no lock, no compare, even with nonsense Q
        do_reset();
        step(1'b1, 2'b00, 4'd1, 4'd9);  chk("nold_err0", 32'(if0.err), 0);
        step(1'b1, 2'b01, 4'd2, 4'd0);  chk("nold_err1", 32'(if0.err), 0);
        step(1'b1, 2'b10, 4'd7, 4'd4);  chk("nold_err2", 32'(if0.err), 0);
        step(1'b0, 2'b11, 4'd3, 4'd1);  chk("nold_err3", 32'(if0.err), 0);
        step(1'b1, 2'b00, 4'd3, 4'd12); chk("nold_err4", 32'(if0.err), 0);
        chk("nold_synced", 32'(if0.synced),  0);
        chk("nold_chkcnt", 32'(if0.chk_cnt), 0);
        chk("nold_errcnt", 32'(if0.err_cnt), 0);

        // STOP_ON_ERR=1: first mismatch freezes everything until reset
        do_reset();
        step(1'b1, 2'b11, 4'd5, 4'd0);
        step(1'b1, 2'b00, 4'd0, 4'd5);
        step(1'b1, 2'b00, 4'd0, 4'd7);
        chk("stop_err",    32'(if1.err),       1);
        chk("stop_errcnt", 32'(if1.err_cnt),   1);
        chk("stop_chkcnt", 32'(if1.chk_cnt),   2);
        chk("stop_fexp",   32'(if1.first_exp), 6);
        chk("stop_fgot",   32'(if1.first_got), 7);
        step(1'b1, 2'b00, 4'd0, 4'd9);
        chk("frz1_err",    32'(if1.err),     0);
        step(1'b1, 2'b00, 4'd0, 4'd0);
        chk("frz2_err",    32'(if1.err),     0);
        chk("frz_errcnt",  32'(if1.err_cnt), 1);
        chk("frz_chkcnt",  32'(if1.chk_cnt), 2);
        chk("frz_synced",  32'(if1.synced),  1);
        chk("frz_fexp",    32'(if1.first_exp), 6);
        do_reset();
        chk("stoprst_synced", 32'(if1.synced),  0);
        chk("stoprst_fail",   32'(if1.fail),    0);
        chk("stoprst_errcnt", 32'(if1.err_cnt), 0);
        chk("stoprst_chkcnt", 32'(if1.chk_cnt), 0);
        chk("stoprst_fgot",   32'(if1.first_got), 0);

        // ERR_W=2: five consecutive mismatches saturate err_cnt at 3
        step(1'b1, 2'b11, 4'd5, 4'd0);
        step(1'b1, 2'b00, 4'd0, 4'd5);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b00, 4'd0, 4'd15);
            chk("sat_err",    32'(if2.err),     1);
            chk("sat_errcnt", 32'(if2.err_cnt), (i < 3) ? i + 1 : 3);
        end
        chk("sat_fexp",   32'(if2.first_exp), 6);
        chk("sat_fgot",   32'(if2.first_got), 15);
        chk("sat_chkcnt", 32'(if2.chk_cnt),   6);
        chk("sat_fail",   32'(if2.fail),      1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
